defuse_ctrl: RTL and testbench
==============================

Name: defuse_ctrl

Overview:
- Game-level sequencer for the bomb-defuse timer board. Consumes the single-cycle button pulses from the per-button one-pulse conditioners and the 1 Hz tick, and runs the arm/countdown/code-entry/verdict state machine.
- Drives the displayed time, tries remaining and the defused/exploded outcome flags.
- Sits between the button conditioners and the display/buzzer logic.

Parameters:
- CODE_LEN, 4: digits per code attempt (2..7).
- START_TIME, 60: seconds loaded on arm (1..255).
- MAX_TRIES, 3: wrong attempts allowed before explosion (1..3).
- PENALTY, 10: seconds removed per wrong attempt (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- btn_pulse  in  4  one-cycle digit pulses; bit i = digit i
- arm_pulse  in  1  one-cycle arm/re-arm request
- tick_1hz  in  1  one-cycle pulse per second
- code_in  in  2*CODE_LEN  secret code; digit k in bits [2k+1:2k], digit 0 entered first
- time_left  out  8  seconds remaining
- tries_left  out  2  attempts remaining
- entry_cnt  out  3  digits entered in current attempt
- state_out  out  3  current state encoding
- defused  out  1  high while in DEFUSED
- exploded  out  1  high while in EXPLODED
- wrong_pulse  out  1  one-cycle pulse on a failed attempt
- multi_err  out  1  one-cycle pulse on a multi-hot btn_pulse

Behaviour:
- Reset is sampled on posedge clk. While reset=0: state=IDLE, time_left=0, tries_left=0, entry_cnt=0, entry shift register=0, latched code=0, and all flags and pulses are 0.
- States and encodings: IDLE=0, ARMED=1, CHECK=2, DEFUSED=3, EXPLODED=4. Codes 5-7 return to IDLE on the next clock with all outputs cleared.
- IDLE, DEFUSED, EXPLODED, on arm_pulse=1:
  - Next state ARMED.
  - time_left=START_TIME, tries_left=MAX_TRIES, entry_cnt=0.
  - code_in is latched; later code_in changes are ignored until the next arm.
  - defused and exploded clear on the same edge.
- ARMED, digit entry:
  - A one-hot btn_pulse shifts its 2-bit index into the entry register and increments entry_cnt.
  - When entry_cnt reaches CODE_LEN, next state is CHECK.
- ARMED, bad or ignored input:
  - btn_pulse=0 does nothing.
  - A multi-hot btn_pulse is ignored (no entry, entry_cnt unchanged) and multi_err pulses for 1 cycle.
  - arm_pulse is ignored.
- CHECK lasts exactly 1 cycle and ignores buttons.
  - Entry equals the latched code: next state DEFUSED; time_left freezes.
  - Mismatch: wrong_pulse=1 for that cycle and tries_left decrements. If the decremented value is 0, next state is EXPLODED. Otherwise next state is ARMED with entry_cnt=0.
- Countdown:
  - In ARMED and CHECK, tick_1hz decrements time_left, saturating at 0.
  - The edge on which time_left becomes 0 moves to EXPLODED, except when that same edge leaves CHECK with a match: DEFUSED wins.
  - In IDLE, DEFUSED and EXPLODED, ticks are ignored.
- Latency: the verdict is visible 1 clock after the digit that completes the code (the CHECK cycle), and the outcome flag rises on the following edge.
- Outputs are registered, with no combinational path from inputs to outputs.
- Reset mid-game returns to IDLE immediately; no state survives.

Optional Feature:
- Macro: DEFUSE_PENALTY_EN.
- Defined: a CHECK mismatch also subtracts PENALTY from time_left, saturating at 0. A tick in the same cycle subtracts a further 1. If the result is 0, the next state is EXPLODED regardless of tries_left.
- Undefined: a mismatch affects only tries_left; the PENALTY parameter is unused.

Test Plan:
- Reset, then reset released with no input → state_out=0, time_left=0, all flags 0 for 20 cycles.
- code_in=8'b11_10_01_00, arm, press digits 0,1,2,3 → CHECK for 1 cycle, then defused=1, state_out=3; time_left frozen at 60 minus ticks seen.
- Same code, enter 0,0,0,0 three times → wrong_pulse three times, tries_left 3→2→1→0, exploded=1 after the third CHECK. Repeat with DEFUSE_PENALTY_EN defined, START_TIME=25 → time_left 25→15→5, then explode by tries.
- START_TIME=2, arm, two ticks, no buttons → time_left 2→1→0, exploded=1 on the second tick edge. A third tick is ignored.
- btn_pulse=4'b0101 in ARMED → multi_err=1 for 1 cycle, entry_cnt unchanged. arm_pulse mid-entry → no reload.
- Final correct digit completes so that the CHECK cycle coincides with the tick taking time_left 1→0 → DEFUSED, not EXPLODED. Separately, reset=0 mid-entry → IDLE next edge; re-arm → entry_cnt=0, tries_left=3.

Source files
------------

// File: rtl/defuse_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : defuse_ctrl_if
// Description : Bus bundle between the bomb-defuse sequencer and its
//               neighbours (button conditioners in, display/buzzer out).
//               slave  : sequencer view (conditioned inputs in, status out)
//               master : driver view   (conditioned inputs out, status in)
// Signals     : btn_pulse[3:0]  one-cycle digit pulses, bit i = digit i
//               arm_pulse       one-cycle arm/re-arm request
//               tick_1hz        one-cycle pulse per second
//               code_in         secret code, digit k in bits [2k+1:2k]
//               time_left[7:0]  seconds remaining
//               tries_left[1:0] attempts remaining
//               entry_cnt[2:0]  digits entered in current attempt
//               state_out[2:0]  current state encoding
//               defused, exploded, wrong_pulse, multi_err
// Revision    : 1.0 - initial release
// ============================================================================
interface defuse_ctrl_if #(
  parameter int CODE_LEN = 4
);
  logic [3:0]            btn_pulse;
  logic                  arm_pulse;
  logic                  tick_1hz;
  logic [2*CODE_LEN-1:0] code_in;
  logic [7:0]            time_left;
  logic [1:0]            tries_left;
  logic [2:0]            entry_cnt;
  logic [2:0]            state_out;
  logic                  defused;
  logic                  exploded;
  logic                  wrong_pulse;
  logic                  multi_err;

  modport slave (
    input  btn_pulse, arm_pulse, tick_1hz, code_in,
    output time_left, tries_left, entry_cnt, state_out,
           defused, exploded, wrong_pulse, multi_err
  );

  modport master (
    output btn_pulse, arm_pulse, tick_1hz, code_in,
    input  time_left, tries_left, entry_cnt, state_out,
           defused, exploded, wrong_pulse, multi_err
  );
endinterface
`default_nettype wire

// File: rtl/defuse_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : defuse_ctrl
// Description : Game sequencer for the bomb-defuse timer board. Runs the
//               arm / countdown / code-entry / verdict state machine from
//               conditioned button pulses and a 1 Hz tick.
// Ports       : clk    system clock
//               reset  synchronous, active-low reset
//               bus    defuse_ctrl_if.slave (inputs: btn_pulse, arm_pulse,
//                      tick_1hz, code_in; outputs: time_left, tries_left,
//                      entry_cnt, state_out, defused, exploded, wrong_pulse,
//                      multi_err) - all outputs registered
// Option      : DEFUSE_PENALTY_EN - a wrong attempt also removes PENALTY
//               seconds (plus 1 for a coincident tick), saturating at 0;
//               reaching 0 that way explodes regardless of tries left.
// Revision    : 1.0 - initial release
// ============================================================================
module defuse_ctrl #(
  parameter int CODE_LEN   = 4,
  parameter int START_TIME = 60,
  parameter int MAX_TRIES  = 3,
  parameter int PENALTY    = 10
) (
  input  wire logic    clk,
  input  wire logic    reset,
  defuse_ctrl_if.slave bus
);

  localparam int           c_W          = 2 * CODE_LEN;
  localparam logic [2:0]   c_CODE_LEN   = 3'(CODE_LEN);
  localparam logic [7:0]   c_START_TIME = 8'(START_TIME);
  localparam logic [1:0]   c_MAX_TRIES  = 2'(MAX_TRIES);
  localparam logic [8:0]   c_PENALTY    = 9'(PENALTY);
`ifdef DEFUSE_PENALTY_EN
  localparam bit           c_PENALTY_EN = 1'b1;
`else
  localparam bit           c_PENALTY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_CHECK    = 3'd2,
    S_DEFUSED  = 3'd3,
    S_EXPLODED = 3'd4
  } state_t;

  state_t         r_state,  w_state_nxt;
  logic [7:0]     r_time,   w_time_nxt;
  logic [1:0]     r_tries,  w_tries_nxt;
  logic [2:0]     r_cnt,    w_cnt_nxt;
  logic [c_W-1:0] r_entry,  w_entry_nxt;
  logic [c_W-1:0] r_code,   w_code_nxt;
  logic           r_wrong,  w_wrong_nxt;
  logic           r_multi,  w_multi_nxt;

  logic [1:0]     w_idx;
  logic           w_onehot;
  logic           w_multihot;
  logic [7:0]     w_time_tick;
  logic [8:0]     w_sub;
  logic [7:0]     w_time_pen;
  logic [2:0]     w_cnt_inc;
  logic           w_complete;
  logic [c_W-1:0] w_shift;
  logic [1:0]     w_unused_oldest;

  // Clearing the lowest set bit leaves a non-zero value only for multi-hot.
  assign w_multihot  = (bus.btn_pulse & (bus.btn_pulse - 4'd1)) != 4'd0;
  assign w_onehot    = (bus.btn_pulse != 4'd0) && !w_multihot;
  assign w_time_tick = (bus.tick_1hz && (r_time != 8'd0)) ? r_time - 8'd1 : r_time;
  assign w_cnt_inc   = r_cnt + 3'd1;
  assign w_complete  = w_onehot && (w_cnt_inc == c_CODE_LEN);
  // New digit enters at the top, so after CODE_LEN digits the first one sits
  // in bits [1:0], lining up directly with the latched code layout.
  assign w_shift         = {w_idx, r_entry[c_W-1:2]};
  assign w_unused_oldest = r_entry[1:0];

  // Penalty path: remove PENALTY plus a coincident tick, floor at zero.
  assign w_sub      = c_PENALTY + {8'd0, bus.tick_1hz};
  assign w_time_pen = ({1'b0, r_time} > w_sub) ? 8'({1'b0, r_time} - w_sub) : 8'd0;

  always_comb begin
    w_idx = 2'd0;
    case (bus.btn_pulse)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_time  <= 8'd0;
      r_tries <= 2'd0;
      r_cnt   <= 3'd0;
      r_entry <= '0;
      r_code  <= '0;
      r_wrong <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_time  <= w_time_nxt;
      r_tries <= w_tries_nxt;
      r_cnt   <= w_cnt_nxt;
      r_entry <= w_entry_nxt;
      r_code  <= w_code_nxt;
      r_wrong <= w_wrong_nxt;
      r_multi <= w_multi_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_tries_nxt = r_tries;
    w_cnt_nxt   = r_cnt;
    w_entry_nxt = r_entry;
    w_code_nxt  = r_code;
    w_wrong_nxt = 1'b0;
    w_multi_nxt = 1'b0;

    case (r_state)
      S_IDLE, S_DEFUSED, S_EXPLODED: begin
        if (bus.arm_pulse) begin
          w_state_nxt = S_ARMED;
          w_time_nxt  = c_START_TIME;
          w_tries_nxt = c_MAX_TRIES;
          w_cnt_nxt   = 3'd0;
          w_entry_nxt = '0;
          w_code_nxt  = bus.code_in;
        end
      end

      S_ARMED: begin
        w_time_nxt = w_time_tick;
        if (w_onehot) begin
          w_entry_nxt = w_shift;
          w_cnt_nxt   = w_cnt_inc;
        end else if (w_multihot) begin
          w_multi_nxt = 1'b1;
        end
        // Running out of time beats a completing digit on the same edge.
        if (w_time_tick == 8'd0) begin
          w_state_nxt = S_EXPLODED;
        end else if (w_complete) begin
          w_state_nxt = S_CHECK;
          // Verdict is computed on entry so it is visible during CHECK.
          w_wrong_nxt = (w_shift != r_code);
        end
      end

      S_CHECK: begin
        w_time_nxt = w_time_tick;
        if (!r_wrong) begin
          // A match wins even if this edge's tick empties the clock.
          w_state_nxt = S_DEFUSED;
        end else begin
          w_tries_nxt = r_tries - 2'd1;
          w_cnt_nxt   = 3'd0;
          if (c_PENALTY_EN) begin
            w_time_nxt = w_time_pen;
          end
          if ((w_tries_nxt == 2'd0) || (w_time_nxt == 8'd0)) begin
            w_state_nxt = S_EXPLODED;
          end else begin
            w_state_nxt = S_ARMED;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_time_nxt  = 8'd0;
        w_tries_nxt = 2'd0;
        w_cnt_nxt   = 3'd0;
        w_entry_nxt = '0;
        w_code_nxt  = '0;
      end
    endcase
  end

  assign bus.time_left   = r_time;
  assign bus.tries_left  = r_tries;
  assign bus.entry_cnt   = r_cnt;
  assign bus.state_out   = r_state;
  assign bus.defused     = (r_state == S_DEFUSED);
  assign bus.exploded    = (r_state == S_EXPLODED);
  assign bus.wrong_pulse = r_wrong;
  assign bus.multi_err   = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_defuse_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_defuse_ctrl
// Description : Self-checking bench for defuse_ctrl. Directed scenarios plus
//               a randomized run compared against a game-rule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_defuse_ctrl;

  localparam int CL      = 4;
  localparam int MAXT    = 3;
  localparam int PEN     = 10;
`ifdef DEFUSE_PENALTY_EN
  localparam int START   = 25;
  localparam bit PEN_EN  = 1'b1;
`else
  localparam int START   = 60;
  localparam bit PEN_EN  = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  defuse_ctrl_if #(.CODE_LEN(CL)) bus ();

  defuse_ctrl #(
    .CODE_LEN  (CL),
    .START_TIME(START),
    .MAX_TRIES (MAXT),
    .PENALTY   (PEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (game rules) ----------------
  int m_st;          // 0 idle, 1 armed, 2 check, 3 defused, 4 exploded
  int m_time;
  int m_tries;
  int m_dig[$];      // digits entered this attempt, in entry order
  int m_code[CL];    // latched code digits
  bit e_wrong;
  bit e_multi;

  function automatic bit code_matches();
    if (m_dig.size() != CL) return 1'b0;
    for (int k = 0; k < CL; k++)
      if (m_dig[k] != m_code[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic rst_n, input logic [3:0] btn,
                            input logic arm, input logic tk,
                            input logic [2*CL-1:0] code);
    int nt;
    int ones;
    bit go_check;
    e_wrong = 1'b0;
    e_multi = 1'b0;
    if (!rst_n) begin
      m_st = 0; m_time = 0; m_tries = 0; m_dig.delete();
      for (int k = 0; k < CL; k++) m_code[k] = 0;
      return;
    end
    ones = $countones(btn);
    nt   = (tk && m_time > 0) ? m_time - 1 : m_time;
    go_check = 1'b0;
    case (m_st)
      1: begin
        if (ones == 1) begin
          for (int d = 0; d < 4; d++) if (btn[d]) m_dig.push_back(d);
          if (m_dig.size() == CL) go_check = 1'b1;
        end else if (ones > 1) begin
          e_multi = 1'b1;
        end
        m_time = nt;
        if (nt == 0) m_st = 4;
        else if (go_check) begin
          m_st = 2;
          e_wrong = !code_matches();
        end
      end
      2: begin
        if (code_matches()) begin
          m_time = nt;
          m_st   = 3;
        end else begin
          m_tries = m_tries - 1;
          if (PEN_EN) nt = (m_time - PEN - int'(tk) > 0) ? m_time - PEN - int'(tk) : 0;
          m_time = nt;
          m_dig.delete();
          m_st = (m_tries == 0 || m_time == 0) ? 4 : 1;
        end
      end
      default: begin
        if (arm) begin
          m_st = 1; m_time = START; m_tries = MAXT; m_dig.delete();
          for (int k = 0; k < CL; k++) m_code[k] = int'(code[2*k +: 2]);
        end
      end
    endcase
  endtask

  // Apply one cycle of inputs, advance the model on the same edge, settle.
  task automatic step(input logic [3:0] btn, input logic arm, input logic tk);
    bus.btn_pulse = btn;
    bus.arm_pulse = arm;
    bus.tick_1hz  = tk;
    @(posedge clk);
    model_edge(reset, btn, arm, tk, bus.code_in);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(4'd0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    bus.code_in = 8'hE4;
    step(4'b0011, 1'b1, 1'b1);
    step(4'b0001, 1'b1, 1'b0);
    n_checks++;
    if (bus.state_out !== 3'd0 || bus.time_left !== 8'd0 || bus.tries_left !== 2'd0 ||
        bus.entry_cnt !== 3'd0 || bus.defused !== 1'b0 || bus.exploded !== 1'b0 ||
        bus.wrong_pulse !== 1'b0 || bus.multi_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: state=%0d time=%0d tries=%0d cnt=%0d flags=%b%b%b%b, need all 0",
               bus.state_out, bus.time_left, bus.tries_left, bus.entry_cnt,
               bus.defused, bus.exploded, bus.wrong_pulse, bus.multi_err);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(4'd0, 1'b0, 1'b0);
      n_checks++;
      if (bus.state_out !== 3'd0 || bus.time_left !== 8'd0 || bus.defused !== 1'b0 ||
          bus.exploded !== 1'b0 || bus.wrong_pulse !== 1'b0 || bus.multi_err !== 1'b0) begin
        n_errors++;
        $display("FAIL idle_hold cyc %0d: state=%0d time=%0d, need state 0 time 0 flags 0",
                 i, bus.state_out, bus.time_left);
      end
    end
  endtask

  task automatic test_defuse();
    do_reset();
    bus.code_in = 8'b11_10_01_00;
    step(4'd0, 1'b1, 1'b0);
    n_checks++;
    if (bus.state_out !== 3'd1 || bus.time_left !== 8'(START) ||
        bus.tries_left !== 2'(MAXT) || bus.entry_cnt !== 3'd0) begin
      n_errors++;
      $display("FAIL arm_load: state=%0d time=%0d tries=%0d cnt=%0d, need 1/%0d/%0d/0",
               bus.state_out, bus.time_left, bus.tries_left, bus.entry_cnt, START, MAXT);
    end
    bus.code_in = 8'h00;   // must not affect the latched code
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    n_checks++;
    if (bus.state_out !== 3'd2 || bus.wrong_pulse !== 1'b0 || bus.entry_cnt !== 3'd4) begin
      n_errors++;
      $display("FAIL check_cycle: state=%0d wrong=%b cnt=%0d, need 2/0/4",
               bus.state_out, bus.wrong_pulse, bus.entry_cnt);
    end
    step(4'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.state_out !== 3'd3 || bus.defused !== 1'b1 || bus.time_left !== 8'(START - 1)) begin
      n_errors++;
      $display("FAIL defused: state=%0d defused=%b time=%0d, need 3/1/%0d",
               bus.state_out, bus.defused, bus.time_left, START - 1);
    end
    for (int i = 0; i < 3; i++) step(4'd0, 1'b0, 1'b1);
    n_checks++;
    if (bus.state_out !== 3'd3 || bus.time_left !== 8'(START - 1)) begin
      n_errors++;
      $display("FAIL frozen: state=%0d time=%0d, need 3/%0d", bus.state_out, bus.time_left, START - 1);
    end
  endtask

  task automatic test_wrong_tries();
    bus.code_in = 8'b11_10_01_00;
    step(4'd0, 1'b1, 1'b0);   // re-arm from DEFUSED
    n_checks++;
    if (bus.defused !== 1'b0 || bus.state_out !== 3'd1) begin
      n_errors++;
      $display("FAIL rearm_clear: defused=%b state=%0d, need 0/1", bus.defused, bus.state_out);
    end
    for (int a = 1; a <= MAXT; a++) begin
      for (int d = 0; d < CL; d++) step(4'b0001, 1'b0, 1'b0);
      n_checks++;
      if (bus.state_out !== 3'd2 || bus.wrong_pulse !== 1'b1) begin
        n_errors++;
        $display("FAIL wrong_pulse try %0d: state=%0d wrong=%b, need 2/1", a, bus.state_out, bus.wrong_pulse);
      end
      step(4'd0, 1'b0, 1'b0);
      n_checks++;
      if (bus.tries_left !== 2'(MAXT - a) || bus.wrong_pulse !== 1'b0 ||
          bus.time_left !== (PEN_EN ? 8'(START - PEN * a > 0 ? START - PEN * a : 0) : 8'(START))) begin
        n_errors++;
        $display("FAIL after_try %0d: tries=%0d wrong=%b time=%0d, need %0d/0/model %0d",
                 a, bus.tries_left, bus.wrong_pulse, bus.time_left, MAXT - a, m_time);
      end
      n_checks++;
      if ((a < MAXT) ? (bus.state_out !== 3'd1 || bus.entry_cnt !== 3'd0)
                     : (bus.state_out !== 3'd4 || bus.exploded !== 1'b1)) begin
        n_errors++;
        $display("FAIL try_state %0d: state=%0d cnt=%0d exploded=%b", a,
                 bus.state_out, bus.entry_cnt, bus.exploded);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= START; i++) begin
      step(4'd0, 1'b0, 1'b1);
      n_checks++;
      if (bus.time_left !== 8'(START - i) || bus.exploded !== (i == START)) begin
        n_errors++;
        $display("FAIL countdown tick %0d: time=%0d exploded=%b, need %0d/%b",
                 i, bus.time_left, bus.exploded, START - i, i == START);
      end
    end
    step(4'd0, 1'b0, 1'b1);
    n_checks++;
    if (bus.time_left !== 8'd0 || bus.state_out !== 3'd4) begin
      n_errors++;
      $display("FAIL tick_after_explode: time=%0d state=%0d, need 0/4", bus.time_left, bus.state_out);
    end
  endtask

  task automatic test_multi_arm();
    do_reset();
    step(4'd0, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    n_checks++;
    if (bus.multi_err !== 1'b1 || bus.entry_cnt !== 3'd1) begin
      n_errors++;
      $display("FAIL multi_hot: multi=%b cnt=%0d, need 1/1", bus.multi_err, bus.entry_cnt);
    end
    step(4'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.multi_err !== 1'b0) begin
      n_errors++;
      $display("FAIL multi_one_cycle: multi=%b, need 0", bus.multi_err);
    end
    step(4'd0, 1'b0, 1'b1);
    step(4'd0, 1'b1, 1'b0);
    n_checks++;
    if (bus.time_left !== 8'(START - 1) || bus.entry_cnt !== 3'd1 || bus.state_out !== 3'd1) begin
      n_errors++;
      $display("FAIL arm_ignored: time=%0d cnt=%0d state=%0d, need %0d/1/1",
               bus.time_left, bus.entry_cnt, bus.state_out, START - 1);
    end
  endtask

  task automatic test_tick_coincide();
    do_reset();
    bus.code_in = 8'b11_10_01_00;
    step(4'd0, 1'b1, 1'b0);
    for (int i = 0; i < START - 1; i++) step(4'd0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    n_checks++;
    if (bus.state_out !== 3'd2 || bus.time_left !== 8'd1) begin
      n_errors++;
      $display("FAIL pre_coincide: state=%0d time=%0d, need 2/1", bus.state_out, bus.time_left);
    end
    step(4'd0, 1'b0, 1'b1);
    n_checks++;
    if (bus.state_out !== 3'd3 || bus.defused !== 1'b1 || bus.exploded !== 1'b0 ||
        bus.time_left !== 8'd0) begin
      n_errors++;
      $display("FAIL coincide: state=%0d def=%b exp=%b time=%0d, need 3/1/0/0",
               bus.state_out, bus.defused, bus.exploded, bus.time_left);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.code_in = 8'b11_10_01_00;
    step(4'd0, 1'b1, 1'b0);
    for (int d = 0; d < CL; d++) step(4'b1000, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    n_checks++;
    if (bus.tries_left !== 2'(MAXT - 1) || bus.entry_cnt !== 3'd2) begin
      n_errors++;
      $display("FAIL mid_entry: tries=%0d cnt=%0d, need %0d/2", bus.tries_left, bus.entry_cnt, MAXT - 1);
    end
    reset = 1'b0;
    step(4'b0100, 1'b0, 1'b1);
    n_checks++;
    if (bus.state_out !== 3'd0 || bus.entry_cnt !== 3'd0 || bus.tries_left !== 2'd0 ||
        bus.time_left !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_mid: state=%0d cnt=%0d tries=%0d time=%0d, need all 0",
               bus.state_out, bus.entry_cnt, bus.tries_left, bus.time_left);
    end
    reset = 1'b1;
    step(4'd0, 1'b1, 1'b0);
    n_checks++;
    if (bus.state_out !== 3'd1 || bus.entry_cnt !== 3'd0 || bus.tries_left !== 2'(MAXT)) begin
      n_errors++;
      $display("FAIL rearm_after_reset: state=%0d cnt=%0d tries=%0d, need 1/0/%0d",
               bus.state_out, bus.entry_cnt, bus.tries_left, MAXT);
    end
  endtask

  task automatic test_random();
    logic [19:0] obs;
    logic [19:0] exp;
    logic [3:0]  btn;
    logic        arm;
    logic        tk;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) == 0) bus.code_in = 8'($urandom);
      arm = ($urandom_range(0, 19) == 0);
      tk  = ($urandom_range(0, 7) == 0);
      btn = 4'd0;
      if ($urandom_range(0, 1) == 0) begin
        if (m_st == 1 && m_dig.size() < CL && $urandom_range(0, 3) != 0)
          btn = 4'(1 << m_code[m_dig.size()]);
        else
          btn = 4'($urandom);
      end
      step(btn, arm, tk);
      exp = {3'(m_st), 8'(m_time), 2'(m_tries), 3'(m_dig.size()),
             m_st == 3, m_st == 4, e_wrong, e_multi};
      obs = {bus.state_out, bus.time_left, bus.tries_left, bus.entry_cnt,
             bus.defused, bus.exploded, bus.wrong_pulse, bus.multi_err};
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL random cyc %0d: got st=%0d t=%0d tr=%0d cnt=%0d flags=%b, need st=%0d t=%0d tr=%0d cnt=%0d flags=%b",
                 c, obs[19:17], obs[16:9], obs[8:7], obs[6:4], obs[3:0],
                 exp[19:17], exp[16:9], exp[8:7], exp[6:4], exp[3:0]);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    bus.btn_pulse = 4'd0;
    bus.arm_pulse = 1'b0;
    bus.tick_1hz  = 1'b0;
    bus.code_in   = '0;
    m_st = 0; m_time = 0; m_tries = 0;
    e_wrong = 1'b0; e_multi = 1'b0;
    for (int k = 0; k < CL; k++) m_code[k] = 0;

    test_reset();
    test_defuse();
    test_wrong_tries();
    test_timeout();
    test_multi_arm();
    test_tick_coincide();
    test_reset_mid();
    test_random();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
